// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-warp register scoreboard between one instruction-buffer
// issue slot and the dispatch stage. Holds instructions with RAW/WAW hazards,
// forwards clean ones through a one-entry output register, releases registers
// on end-of-packet writeback (with same-cycle bypass), and keeps stall
// statistics plus a sticky deadlock watchdog.
module issue_scoreboard #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64,
  parameter int DATAW     = 128,
  parameter int TIMEOUT   = 65535,
  localparam int WISW     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NRW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ibuf_valid,
  output logic             ibuf_ready,
  input  logic [WISW-1:0]  ibuf_wis,
  input  logic             ibuf_wb,
  input  logic [NRW-1:0]   ibuf_rd,
  input  logic [NRW-1:0]   ibuf_rs1,
  input  logic [NRW-1:0]   ibuf_rs2,
  input  logic [NRW-1:0]   ibuf_rs3,
  input  logic [DATAW-1:0] ibuf_data,
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [DATAW-1:0] disp_data,
  output logic [WISW-1:0]  disp_wis,
  input  logic             wb_valid,
  input  logic             wb_eop,
  input  logic [WISW-1:0]  wb_wis,
  input  logic [NRW-1:0]   wb_rd,
  output logic [31:0]      perf_stalls,
  output logic             stall_timeout
);

  // The run counter only has to reach TIMEOUT-1 before it saturates.
  localparam int RUNW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RUNW-1:0] RUN_LAST = RUNW'(TIMEOUT - 1);
  localparam logic [RUNW-1:0] RUN_ONE  = RUNW'(1);
  localparam logic [RUNW-1:0] RUN_ZERO = RUNW'(0);
  localparam logic [NUM_REGS-1:0] REG_ONE  = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0] REG_ZERO = NUM_REGS'(0);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] r_inuse;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] w_inuse_nxt;
  logic                r_disp_valid;
  logic [DATAW-1:0]    r_disp_data;
  logic [WISW-1:0]     r_disp_wis;
  logic [31:0]         r_perf;
  logic [RUNW-1:0]     r_run;
  logic                r_timeout;

  logic                w_rel;
  logic                w_set;
  logic [NUM_REGS-1:0] w_rel_onehot;
  logic [NUM_REGS-1:0] w_set_onehot;
  logic [NUM_REGS-1:0] w_row_clr;
  logic [NUM_REGS-1:0] w_row;
  logic                w_hz;
  logic                w_space;
  logic                w_ready;
  logic                w_fire;
  logic                w_stall;

  // Release/set decode; register 0 is never tracked so it can never hazard.
  assign w_rel        = wb_valid && wb_eop && (wb_rd != {NRW{1'b0}});
  assign w_rel_onehot = REG_ONE << wb_rd;
  assign w_set_onehot = REG_ONE << ibuf_rd;
  assign w_set        = w_fire && ibuf_wb && (ibuf_rd != {NRW{1'b0}});

  // Effective in-use row for the requesting warp, with this cycle's release bypassed in.
  assign w_row_clr = (w_rel && (wb_wis == ibuf_wis)) ? w_rel_onehot : REG_ZERO;
  assign w_row     = r_inuse[ibuf_wis] & ~w_row_clr;

  assign w_hz    = w_row[ibuf_rs1] | w_row[ibuf_rs2] | w_row[ibuf_rs3] |
                   (ibuf_wb & w_row[ibuf_rd]);
  assign w_space = !r_disp_valid || disp_ready;
  assign w_ready = ibuf_valid && !w_hz && w_space;
  assign w_fire  = ibuf_valid && w_ready;
  assign w_stall = ibuf_valid && w_hz;

  // Next scoreboard: release clears first, then set is applied so a collision leaves the bit set.
  always_comb begin
    w_inuse_nxt = r_inuse;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_inuse_nxt[w] = (r_inuse[w] &
                        ~((w_rel && (wb_wis == WISW'(w))) ? w_rel_onehot : REG_ZERO)) |
                       ((w_set && (ibuf_wis == WISW'(w))) ? w_set_onehot : REG_ZERO);
    end
  end

  // Scoreboard bitmap register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inuse <= {(NUM_WARPS*NUM_REGS){1'b0}};
    end else begin
      r_inuse <= w_inuse_nxt;
    end
  end

  // One-entry dispatch register: load on accept, drain on dispatch, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp_valid <= 1'b0;
      r_disp_data  <= {DATAW{1'b0}};
      r_disp_wis   <= {WISW{1'b0}};
    end else if (w_fire) begin
      r_disp_valid <= 1'b1;
      r_disp_data  <= ibuf_data;
      r_disp_wis   <= ibuf_wis;
    end else if (disp_ready) begin
      r_disp_valid <= 1'b0;
    end
  end

  // Saturating count of hazard-stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf <= 32'd0;
    end else if (w_stall && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  // Watchdog: length of the current stall run, sticky flag once it reaches TIMEOUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run     <= RUN_ZERO;
      r_timeout <= 1'b0;
    end else if (w_stall) begin
      if (r_run == RUN_LAST) begin
        r_timeout <= 1'b1;
      end else begin
        r_run <= r_run + RUN_ONE;
      end
    end else begin
      r_run <= RUN_ZERO;
    end
  end

  assign ibuf_ready    = w_ready;
  assign disp_valid    = r_disp_valid;
  assign disp_data     = r_disp_data;
  assign disp_wis      = r_disp_wis;
  assign perf_stalls   = r_perf;
  assign stall_timeout = r_timeout;

endmodule
